// File: rtl/vga_pkg.sv
// vga_pkg: shared constants for the 1280x800 raster path.
//   - Default horizontal/vertical timing (active, porches, sync, totals).
//   - Coordinate widths X_W / Y_W.
//   - Draw-stage latency (cycles from draw_x/draw_y to valid pix_*).
//   - sync_t: the per-cycle {active, hs, vs} bundle carried down the delay line.
package vga_pkg;
   localparam int X_W = 11;
   localparam int Y_W = 10;

   localparam int H_ACTIVE_D = 1280;
   localparam int H_FP_D     = 64;
   localparam int H_SYNC_D   = 136;
   localparam int H_BP_D     = 200;
   localparam int H_TOTAL_D  = H_ACTIVE_D + H_FP_D + H_SYNC_D + H_BP_D;

   localparam int V_ACTIVE_D = 800;
   localparam int V_FP_D     = 1;
   localparam int V_SYNC_D   = 3;
   localparam int V_BP_D     = 24;
   localparam int V_TOTAL_D  = V_ACTIVE_D + V_FP_D + V_SYNC_D + V_BP_D;

   localparam int PIPE_DLY_D = 2;

   typedef struct packed {
      logic active;
      logic hs;
      logic vs;
   } sync_t;
endpackage

// File: rtl/vga_timing_gen_sync_delay.sv
// sync_delay: DEPTH-stage shift register for the {active, hs, vs} bundle.
// Ports:
//   clk, rst : clock, asynchronous active-high reset (clears every stage)
//   d_i      : bundle derived from the current counters
//   q_o      : the same bundle DEPTH cycles later
module sync_delay #(
   parameter int DEPTH = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] d_i,
   output logic [2:0] q_o
);
   logic [DEPTH-1:0][2:0] pipe_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pipe_q <= '0;
      end else begin
         pipe_q[0] <= d_i;
         for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
      end
   end

   assign q_o = pipe_q[DEPTH-1];
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster counters, sync generation and blanked colour output.
// Ports:
//   clk, rst            : pixel clock, asynchronous active-high reset
//   draw_x, draw_y      : raw scan counters (include blanking region)
//   frame_tick          : one-cycle pulse at (0, V_ACTIVE), aligned with counters
//   pix_r/g/b           : colour from the draw stage, PIPE_DLY cycles behind coords
//   vga_r/g/b           : registered colour, forced to 0 outside the active area
//   hsync, vsync        : registered syncs, aligned with vga_*
//   frame_cnt           : frame counter, only when VGA_FRAME_CNT_EN is defined
// Counter-to-pin latency is PIPE_DLY+1 for both colour and syncs.
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int   H_ACTIVE = H_ACTIVE_D,
   parameter int   H_FP     = H_FP_D,
   parameter int   H_SYNC   = H_SYNC_D,
   parameter int   H_BP     = H_BP_D,
   parameter int   V_ACTIVE = V_ACTIVE_D,
   parameter int   V_FP     = V_FP_D,
   parameter int   V_SYNC   = V_SYNC_D,
   parameter int   V_BP     = V_BP_D,
   parameter logic H_POL    = 1'b0,
   parameter logic V_POL    = 1'b1,
   parameter int   PIPE_DLY = PIPE_DLY_D
) (
   input  logic           clk,
   input  logic           rst,
   output logic [X_W-1:0] draw_x,
   output logic [Y_W-1:0] draw_y,
   output logic           frame_tick,
   input  logic [3:0]     pix_r,
   input  logic [3:0]     pix_g,
   input  logic [3:0]     pix_b,
   output logic [3:0]     vga_r,
   output logic [3:0]     vga_g,
   output logic [3:0]     vga_b,
   output logic           hsync,
   output logic           vsync
`ifdef VGA_FRAME_CNT_EN
   ,
   output logic [15:0]    frame_cnt
`endif
);
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   if (H_TOTAL > (1 << X_W) || V_TOTAL > (1 << Y_W) || PIPE_DLY < 1) begin : g_cfg_chk
      $error("vga_timing_gen: timing does not fit counter widths or PIPE_DLY < 1");
   end

   localparam logic [X_W-1:0] X_LAST   = X_W'(H_TOTAL - 1);
   localparam logic [Y_W-1:0] Y_LAST   = Y_W'(V_TOTAL - 1);
   localparam logic [X_W-1:0] X_ACT    = X_W'(H_ACTIVE);
   localparam logic [Y_W-1:0] Y_ACT    = Y_W'(V_ACTIVE);
   localparam logic [X_W-1:0] HS_START = X_W'(H_ACTIVE + H_FP);
   localparam logic [X_W-1:0] HS_END   = X_W'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [Y_W-1:0] VS_START = Y_W'(V_ACTIVE + V_FP);
   localparam logic [Y_W-1:0] VS_END   = Y_W'(V_ACTIVE + V_FP + V_SYNC - 1);

   logic [X_W-1:0] x_q, x_d;
   logic [Y_W-1:0] y_q, y_d;
   logic           tick_q, tick_d;
   logic [3:0]     r_q, g_q, b_q;
   logic           hs_q, vs_q;
   sync_t          cur, dly;

   always_comb begin
      x_d = x_q + 1'b1;
      y_d = y_q;
      if (x_q == X_LAST) begin
         x_d = '0;
         y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
      end
      // Registered so the pulse lands in the same cycle the counters show (0, V_ACTIVE).
      tick_d = (x_d == '0) && (y_d == Y_ACT);
   end

   always_comb begin
      cur.active = (x_q < X_ACT) && (y_q < Y_ACT);
      cur.hs     = (x_q >= HS_START) && (x_q <= HS_END);
      cur.vs     = (y_q >= VS_START) && (y_q <= VS_END);
   end

   sync_delay #(.DEPTH(PIPE_DLY)) u_sync_delay (
      .clk (clk),
      .rst (rst),
      .d_i (cur),
      .q_o (dly)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x_q    <= '0;
         y_q    <= '0;
         tick_q <= 1'b0;
         r_q    <= '0;
         g_q    <= '0;
         b_q    <= '0;
         hs_q   <= ~H_POL;
         vs_q   <= ~V_POL;
      end else begin
         x_q    <= x_d;
         y_q    <= y_d;
         tick_q <= tick_d;
         r_q    <= dly.active ? pix_r : 4'd0;
         g_q    <= dly.active ? pix_g : 4'd0;
         b_q    <= dly.active ? pix_b : 4'd0;
         hs_q   <= dly.hs ? H_POL : ~H_POL;
         vs_q   <= dly.vs ? V_POL : ~V_POL;
      end
   end

`ifdef VGA_FRAME_CNT_EN
   logic [15:0] fcnt_q;
   always_ff @(posedge clk or posedge rst) begin
      if (rst)         fcnt_q <= '0;
      else if (tick_q) fcnt_q <= fcnt_q + 16'd1;
   end
   assign frame_cnt = fcnt_q;
`endif

   assign draw_x     = x_q;
   assign draw_y     = y_q;
   assign frame_tick = tick_q;
   assign vga_r      = r_q;
   assign vga_g      = g_q;
   assign vga_b      = b_q;
   assign hsync      = hs_q;
   assign vsync      = vs_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen. Two instances share clock and reset:
//   big   : default 1280x800 timing, pix_* tied to 15 (horizontal + blanking).
//   small : 8x4 active, H_TOTAL=16, V_TOTAL=8 (frame = 128 cycles) so vertical
//           sync, frame wrap and frame_tick period fit in a short run.
//           pix_r comes from a 2-cycle model of the draw stage (x[3:0]).
// Cycle n = value seen after n rising edges since reset release.
module tb_vga_timing_gen;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // small instance
   logic [10:0] s_x;
   logic [9:0]  s_y;
   logic        s_ft, s_hs, s_vs;
   logic [3:0]  s_pr, s_pg, s_pb, s_r, s_g, s_b;
   logic [3:0]  s_d1, s_d2;
   // big instance
   logic [10:0] b_x;
   logic [9:0]  b_y;
   logic        b_ft, b_hs, b_vs;
   logic [3:0]  b_p, b_r, b_g, b_b;
`ifdef VGA_FRAME_CNT_EN
   logic [15:0] s_fc, b_fc;
`endif

   assign s_pg = 4'hA;
   assign s_pb = 4'h5;
   assign b_p  = 4'hF;

   // draw-stage model: colour for coordinate t is presented at t+2
   always @(posedge clk) begin
      s_d1 <= s_x[3:0];
      s_d2 <= s_d1;
   end
   assign s_pr = s_d2;

   vga_timing_gen #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
      .H_POL(1'b0), .V_POL(1'b1), .PIPE_DLY(2)
   ) u_small (
      .clk(clk), .rst(rst), .draw_x(s_x), .draw_y(s_y), .frame_tick(s_ft),
      .pix_r(s_pr), .pix_g(s_pg), .pix_b(s_pb),
      .vga_r(s_r), .vga_g(s_g), .vga_b(s_b), .hsync(s_hs), .vsync(s_vs)
`ifdef VGA_FRAME_CNT_EN
      , .frame_cnt(s_fc)
`endif
   );

   vga_timing_gen u_big (
      .clk(clk), .rst(rst), .draw_x(b_x), .draw_y(b_y), .frame_tick(b_ft),
      .pix_r(b_p), .pix_g(b_p), .pix_b(b_p),
      .vga_r(b_r), .vga_g(b_g), .vga_b(b_b), .hsync(b_hs), .vsync(b_vs)
`ifdef VGA_FRAME_CNT_EN
      , .frame_cnt(b_fc)
`endif
   );

   typedef struct {
      int n;
      bit big;
      int x;
      int y;
      bit hs;
      bit vs;
      int r;
      bit ft;
   } vec_t;

   vec_t tbl[$];
   int   n_pass = 0;
   int   n_tot  = 0;

   task automatic chk(input string name, input int n, input int act, input int exp);
      n_tot++;
      if (act == exp) n_pass++;
      else $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, n, act, exp);
   endtask

   initial begin
      int ft_cnt, hs_low, cn, ex_x;
      bit act;

      // {n, big, x, y, hsync, vsync, vga_r, frame_tick}
      tbl.push_back('{0,   0, 0,  0, 1, 0, 0, 0});
      tbl.push_back('{1,   0, 1,  0, 1, 0, 0, 0});
      tbl.push_back('{2,   0, 2,  0, 1, 0, 0, 0});
      tbl.push_back('{4,   0, 4,  0, 1, 0, 1, 0});
      tbl.push_back('{10,  0, 10, 0, 1, 0, 7, 0});
      tbl.push_back('{11,  0, 11, 0, 1, 0, 0, 0});
      tbl.push_back('{12,  0, 12, 0, 1, 0, 0, 0});
      tbl.push_back('{13,  0, 13, 0, 0, 0, 0, 0});
      tbl.push_back('{15,  0, 15, 0, 0, 0, 0, 0});
      tbl.push_back('{16,  0, 0,  1, 1, 0, 0, 0});
      tbl.push_back('{20,  0, 4,  1, 1, 0, 1, 0});
      tbl.push_back('{63,  0, 15, 3, 0, 0, 0, 0});
      tbl.push_back('{64,  0, 0,  4, 1, 0, 0, 1});
      tbl.push_back('{65,  0, 1,  4, 1, 0, 0, 0});
      tbl.push_back('{68,  0, 4,  4, 1, 0, 0, 0});
      tbl.push_back('{82,  0, 2,  5, 1, 0, 0, 0});
      tbl.push_back('{83,  0, 3,  5, 1, 1, 0, 0});
      tbl.push_back('{114, 0, 2,  7, 1, 1, 0, 0});
      tbl.push_back('{115, 0, 3,  7, 1, 0, 0, 0});
      tbl.push_back('{127, 0, 15, 7, 0, 0, 0, 0});
      tbl.push_back('{128, 0, 0,  0, 1, 0, 0, 0});
      tbl.push_back('{132, 0, 4,  0, 1, 0, 1, 0});
      tbl.push_back('{191, 0, 15, 3, 0, 0, 0, 0});
      tbl.push_back('{192, 0, 0,  4, 1, 0, 0, 1});
      tbl.push_back('{2,    1, 2,    0, 1, 0, 0,  0});
      tbl.push_back('{3,    1, 3,    0, 1, 0, 15, 0});
      tbl.push_back('{1282, 1, 1282, 0, 1, 0, 15, 0});
      tbl.push_back('{1283, 1, 1283, 0, 1, 0, 0,  0});
      tbl.push_back('{1346, 1, 1346, 0, 1, 0, 0,  0});
      tbl.push_back('{1347, 1, 1347, 0, 0, 0, 0,  0});
      tbl.push_back('{1482, 1, 1482, 0, 0, 0, 0,  0});
      tbl.push_back('{1483, 1, 1483, 0, 1, 0, 0,  0});
      tbl.push_back('{1679, 1, 1679, 0, 1, 0, 0,  0});
      tbl.push_back('{1680, 1, 0,    1, 1, 0, 0,  0});
      tbl.push_back('{1683, 1, 3,    1, 1, 0, 15, 0});

      repeat (3) @(negedge clk);
      // reset state while rst is held
      chk("rst_x", 0, int'(b_x), 0);
      chk("rst_hsync", 0, int'(b_hs), 1);
      chk("rst_vsync", 0, int'(b_vs), 0);
      chk("rst_vga_g", 0, int'(s_g), 0);
      rst = 1'b0;

      ft_cnt = 0;
      hs_low = 0;
      for (int n = 0; n <= 1700; n++) begin
         foreach (tbl[i]) begin
            if (tbl[i].n == n) begin
               if (tbl[i].big) begin
                  chk("big_x", n, int'(b_x), tbl[i].x);
                  chk("big_y", n, int'(b_y), tbl[i].y);
                  chk("big_hsync", n, int'(b_hs), int'(tbl[i].hs));
                  chk("big_vsync", n, int'(b_vs), int'(tbl[i].vs));
                  chk("big_vga_r", n, int'(b_r), tbl[i].r);
                  chk("big_tick", n, int'(b_ft), int'(tbl[i].ft));
               end else begin
                  chk("sm_x", n, int'(s_x), tbl[i].x);
                  chk("sm_y", n, int'(s_y), tbl[i].y);
                  chk("sm_hsync", n, int'(s_hs), int'(tbl[i].hs));
                  chk("sm_vsync", n, int'(s_vs), int'(tbl[i].vs));
                  chk("sm_vga_r", n, int'(s_r), tbl[i].r);
                  chk("sm_tick", n, int'(s_ft), int'(tbl[i].ft));
               end
            end
         end
         // alignment / blanking on the small instance over 1.5 frames
         if (n >= 3 && n <= 200) begin
            cn   = n - 3;
            ex_x = cn % 16;
            act  = (ex_x < 8) && (((cn / 16) % 8) < 4);
            chk("sm_align_r", n, int'(s_r), act ? ex_x : 0);
            chk("sm_blank_g", n, int'(s_g), act ? 10 : 0);
            chk("sm_blank_b", n, int'(s_b), act ? 5 : 0);
         end
         if (n <= 200 && s_ft) ft_cnt++;
         if (!b_hs) hs_low++;
`ifdef VGA_FRAME_CNT_EN
         if (n == 64)  chk("fcnt0", n, int'(s_fc), 0);
         if (n == 65)  chk("fcnt1", n, int'(s_fc), 1);
         if (n == 193) chk("fcnt2", n, int'(s_fc), 2);
`endif
         @(negedge clk);
      end
      chk("tick_count", 200, ft_cnt, 2);
      chk("hsync_width", 1700, hs_low, 136);

      // mid-frame reset: cycle 1701, small coords at 1698 -> (2,2) active
      chk("pre_rst_vga_r", 1701, int'(s_r), 2);
      #2 rst = 1'b1;
      #1;
      chk("arst_big_x", 1701, int'(b_x), 0);
      chk("arst_big_y", 1701, int'(b_y), 0);
      chk("arst_sm_x", 1701, int'(s_x), 0);
      chk("arst_sm_y", 1701, int'(s_y), 0);
      chk("arst_hsync", 1701, int'(s_hs), 1);
      chk("arst_vsync", 1701, int'(s_vs), 0);
      chk("arst_vga_r", 1701, int'(s_r), 0);
      chk("arst_vga_g", 1701, int'(s_g), 0);
      chk("arst_vga_b", 1701, int'(s_b), 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         chk("rel_x", k, int'(b_x), k);
         chk("rel_y", k, int'(b_y), 0);
         @(negedge clk);
      end

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end
endmodule
